step_phase_decoder: RTL



---
 rtl/step_pkg.sv | 29 ++
 rtl/phase_filter.sv | 62 ++++++
 rtl/step_phase_decoder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/step_pkg.sv
// Shared definitions for the stepper phase decoder and the on-chip step driver.
//   decoder_state_t : reference-tracking states of the phase decoder
//   PH_D..PH_A      : phase index of each coil; forward order is D, C, B, A
//   CLK_HZ          : system clock frequency
//   phase_index()   : index of the set bit of a one-hot phase vector {a,b,c,d}
package step_pkg;

  typedef enum logic [1:0] {
    NO_REF    = 2'd0,
    ENERGIZED = 2'd1,
    RELEASED  = 2'd2
  } decoder_state_t;

  localparam logic [1:0] PH_D = 2'd0;
  localparam logic [1:0] PH_C = 2'd1;
  localparam logic [1:0] PH_B = 2'd2;
  localparam logic [1:0] PH_A = 2'd3;

  localparam int CLK_HZ = 50_000_000;

  // Only meaningful for a one-hot vector; bit position equals phase index.
  function automatic logic [1:0] phase_index(input logic [3:0] vec);
    if (vec[PH_A]) return PH_A;
    if (vec[PH_B]) return PH_B;
    if (vec[PH_C]) return PH_C;
    return PH_D;
  endfunction

endpackage

// File: rtl/phase_filter.sv
// Synchronizer and stability filter for the 4-bit coil-phase vector.
//   clk, reset : system clock, asynchronous active-low reset
//   phase_in   : raw phase vector {a,b,c,d}
//   vec        : last accepted (filtered) vector
//   accept     : one-cycle strobe when vec is (re)loaded
module phase_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] phase_in,
  output logic [3:0] vec,
  output logic       accept
);

  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]                  sync_vec;
  logic [3:0]                  cand;
  logic [CNT_W-1:0]            stable_cnt;
  logic [CNT_W-1:0]            cnt_next;
  logic                        changed;
  logic                        hit;

  assign sync_vec = sync_q[SYNC_STAGES-1];

  // stable_cnt counts how many cycles sync_vec has equalled cand, including
  // the cycle it first appeared, so a vector present for FILTER_CYCLES
  // cycles is accepted exactly once, on the cycle the count gets there.
  always_comb begin
    changed = (sync_vec != cand);
    if (changed)
      cnt_next = CNT_ONE;
    else if (stable_cnt == CNT_MAX)
      cnt_next = stable_cnt;
    else
      cnt_next = stable_cnt + CNT_ONE;
    hit = (cnt_next == CNT_MAX) && (changed || (stable_cnt != CNT_MAX));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= '0;
      cand       <= 4'b0000;
      stable_cnt <= '0;
      vec        <= 4'b0000;
      accept     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], phase_in};
      cand       <= sync_vec;
      stable_cnt <= cnt_next;
      accept     <= hit;
      if (hit)
        vec <= sync_vec;
    end
  end

endmodule

// File: rtl/step_phase_decoder.sv
// Decodes a 4-phase full-step coil bus into direction, signed position,
// step period and error flags.
//   clk, reset           : system clock, asynchronous active-low reset
//   phase_a..phase_d     : coil phase lines
//   clear_pos, clear_err : synchronous clear pulses
//   position, dir        : signed step count, direction of last counted step
//   step_pulse           : one-cycle strobe per counted step
//   step_period, moving  : cycles between last two steps, recent-step flag
//   energized            : registered state == ENERGIZED
//   err_skip, err_multi  : sticky skip / multi-phase flags
//
// state     | meaning
// NO_REF    | no reference phase held; next one-hot vector only loads it
// ENERGIZED | one-hot vector accepted; reference = its index
// RELEASED  | all-zero after ENERGIZED; reference retained for resume
module step_phase_decoder import step_pkg::*; #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 16,
  parameter int POS_W         = 32,
  parameter int PER_W         = 32,
  parameter int STALL_CYCLES  = CLK_HZ / 250
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    phase_a,
  input  logic                    phase_b,
  input  logic                    phase_c,
  input  logic                    phase_d,
  input  logic                    clear_pos,
  input  logic                    clear_err,
  output logic signed [POS_W-1:0] position,
  output logic                    dir,
  output logic                    step_pulse,
  output logic [PER_W-1:0]        step_period,
  output logic                    moving,
  output logic                    energized,
  output logic                    err_skip,
  output logic                    err_multi
);

  localparam logic [PER_W-1:0] PER_MAX = '1;
  localparam logic [PER_W-1:0] STALL_C = PER_W'(STALL_CYCLES);
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

  logic [3:0]       acc_vec;
  logic             accept;
  decoder_state_t   state, state_next;
  logic [1:0]       ref_idx, new_idx, idx_delta;
  logic             vec_zero, vec_onehot, vec_multi, decode_en;
  logic             step_fwd, step_rev, step_skip, step_any;
  logic [PER_W-1:0] per_cnt, per_inc;
  logic [POS_W-1:0] pos_base;

  phase_filter #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_filter (
    .clk      (clk),
    .reset    (reset),
    .phase_in ({phase_a, phase_b, phase_c, phase_d}),
    .vec      (acc_vec),
    .accept   (accept)
  );

  always_comb begin
    vec_zero   = (acc_vec == 4'b0000);
    vec_onehot = $onehot(acc_vec);
    vec_multi  = !vec_zero && !vec_onehot;
    new_idx    = phase_index(acc_vec);
    // Modulo-4 distance from the reference: 1 = forward, 3 = reverse, 2 = skip.
    idx_delta  = new_idx - ref_idx;
    decode_en  = accept && vec_onehot && (state != NO_REF);
    step_fwd   = decode_en && (idx_delta == 2'd1);
    step_rev   = decode_en && (idx_delta == 2'd3);
    step_skip  = decode_en && (idx_delta == 2'd2);
    step_any   = step_fwd || step_rev;
    per_inc    = (per_cnt == PER_MAX) ? per_cnt : per_cnt + 1'b1;
    // A step in the same cycle as clear_pos counts from zero.
    pos_base   = clear_pos ? '0 : position;

    state_next = state;
    if (accept) begin
      if (vec_multi)
        state_next = NO_REF;
      else if (vec_onehot)
        state_next = ENERGIZED;
      else if (state == ENERGIZED)
        state_next = RELEASED;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= NO_REF;
      ref_idx     <= PH_D;
      position    <= '0;
      dir         <= 1'b0;
      step_pulse  <= 1'b0;
      step_period <= '0;
      per_cnt     <= '0;
      moving      <= 1'b0;
      energized   <= 1'b0;
      err_skip    <= 1'b0;
      err_multi   <= 1'b0;
    end else begin
      state      <= state_next;
      energized  <= (state_next == ENERGIZED);
      step_pulse <= step_any;

      // Every accepted one-hot vector becomes the new reference, including skips.
      if (accept && vec_onehot)
        ref_idx <= new_idx;

      if (step_any) begin
        per_cnt     <= '0;
        step_period <= per_inc;
        moving      <= 1'b1;
        dir         <= step_rev;
        position    <= step_rev ? pos_base - POS_ONE : pos_base + POS_ONE;
      end else begin
        per_cnt <= per_inc;
        if (per_inc == STALL_C)
          moving <= 1'b0;
        if (clear_pos)
          position <= '0;
      end

      // A new error wins over a coincident clear.
      err_skip  <= (err_skip && !clear_err) || step_skip;
      err_multi <= (err_multi && !clear_err) || (accept && vec_multi);
    end
  end

endmodule
